// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front end (tap window) and the MAC stage.
// Both blocks take their default sizes from here so they always elaborate
// from a single source.
//   DEFAULT_DATA_WIDTH : signed sample width in bits
//   DEFAULT_NUM_REGS   : number of taps in the delay line
//   DEFAULT_Q_FORMAT   : fractional bits of the coefficient format (MAC side)
package fir_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_NUM_REGS   = 8;
  localparam int DEFAULT_Q_FORMAT   = 15;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } tap_state_t;

endpackage

// File: rtl/fir_tap_shift.sv
// Enable-plus-clear shift register with parallel output.
//   clk   : system clock, rising edge
//   rstN  : asynchronous active-low reset, clears every tap
//   en    : shift din into tap 0 and move every tap one place older
//   clr   : synchronous clear of every tap, wins over en
//   din   : sample entering the line
//   taps  : parallel tap view, element 0 is the newest sample
module fir_tap_shift
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic                                 en,
  input  logic                                 clr,
  input  logic signed [DATA_WIDTH-1:0]         din,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  taps
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] taps_p0;

  // stage p0: tap delay line
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      taps_p0 <= '0;
    end else if (clr) begin
      taps_p0 <= '0;
    end else if (en) begin
      taps_p0[0] <= din;
      for (int i = 1; i < NUM_REGS; i++) begin
        taps_p0[i] <= taps_p0[i-1];
      end
    end
  end

  assign taps = taps_p0;

endmodule

// File: rtl/fir_tap_window.sv
// Front end for the FIR multiply-accumulate stage. Samples arrive on a
// valid/ready handshake, are shifted into a NUM_REGS-deep tap line, and the
// whole window is presented in parallel to the MAC on a second valid/ready
// handshake. A single output slot with ready pass-through gives one sample
// per clock when downstream keeps up and freezes the taps when it stalls.
//   clk         : system clock, rising edge
//   rstN        : asynchronous active-low reset
//   sampleIn    : signed sensor sample
//   sampleValid : sampleIn is valid
//   sampleReady : sample is taken this cycle when sampleValid is also high
//   flush       : synchronous clear of taps, fill count and pending window
//   pDataOut    : tap window, element 0 is the newest sample
//   windowValid : pDataOut holds a window not yet consumed
//   windowReady : downstream takes the window this cycle
//   fillCount   : samples held, saturating at NUM_REGS
module fir_tap_window
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter bit ZERO_PRIME = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic signed [DATA_WIDTH-1:0]         sampleIn,
  input  logic                                 sampleValid,
  output logic                                 sampleReady,
  input  logic                                 flush,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataOut,
  output logic                                 windowValid,
  input  logic                                 windowReady,
  output logic [$clog2(NUM_REGS+1)-1:0]        fillCount
);

  localparam int CNT_W = $clog2(NUM_REGS+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_REGS);

  if (NUM_REGS < 2) begin : g_bad_num_regs
    $error("fir_tap_window: NUM_REGS must be at least 2");
  end

  tap_state_t       state_p0, state_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt, cnt_inc;
  logic             vld_p0, vld_nxt;
  logic             accept;

  // Single output slot: a new sample may enter whenever the slot is empty
  // or is being drained in this same cycle.
  assign sampleReady = ~flush & (~vld_p0 | windowReady);
  assign accept      = sampleValid & sampleReady;

  assign cnt_inc = (cnt_p0 == CNT_MAX) ? cnt_p0 : cnt_p0 + 1'b1;

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    vld_nxt   = vld_p0;
    if (flush) begin
      state_nxt = EMPTY;
      cnt_nxt   = '0;
      vld_nxt   = 1'b0;
    end else if (accept) begin
      cnt_nxt   = cnt_inc;
      state_nxt = (cnt_inc == CNT_MAX) ? FULL : FILLING;
      // With zero priming the line counts as preloaded, so every sample
      // issues a window; otherwise only a full line does.
      vld_nxt   = ZERO_PRIME ? 1'b1 : (cnt_inc == CNT_MAX);
    end else if (vld_p0 && windowReady) begin
      vld_nxt   = 1'b0;
    end
  end

  // stage p0: control registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_p0 <= EMPTY;
      cnt_p0   <= '0;
      vld_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      vld_p0   <= vld_nxt;
    end
  end

  fir_tap_shift #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_shift (
    .clk (clk),
    .rstN(rstN),
    .en  (accept),
    .clr (flush),
    .din (sampleIn),
    .taps(pDataOut)
  );

  assign windowValid = vld_p0;
  assign fillCount   = cnt_p0;

endmodule

// File: tb/tb_fir_tap_window.sv
module tb_fir_tap_window;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rstN;
  logic flush, windowReady;

  logic signed [DW-1:0] sampleIn;
  logic                 sampleValid;
  logic                 sampleReady;
  logic [NR-1:0][DW-1:0] pDataOut;
  logic                 windowValid;
  logic [3:0]           fillCount;

  logic signed [DW-1:0] z_sampleIn;
  logic                 z_sampleValid;
  logic                 z_sampleReady;
  logic [NR-1:0][DW-1:0] z_pDataOut;
  logic                 z_windowValid;
  logic [3:0]           z_fillCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_tap_window #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_PRIME(1'b0)) dut (
    .clk(clk), .rstN(rstN), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .sampleReady(sampleReady), .flush(flush), .pDataOut(pDataOut),
    .windowValid(windowValid), .windowReady(windowReady), .fillCount(fillCount)
  );

  fir_tap_window #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_PRIME(1'b1)) dut_z (
    .clk(clk), .rstN(rstN), .sampleIn(z_sampleIn), .sampleValid(z_sampleValid),
    .sampleReady(z_sampleReady), .flush(flush), .pDataOut(z_pDataOut),
    .windowValid(z_windowValid), .windowReady(windowReady), .fillCount(z_fillCount)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Window of consecutive samples, newest at element 0.
  function automatic logic [127:0] mkwin(input int newest);
    logic [NR-1:0][DW-1:0] w;
    for (int i = 0; i < NR; i++) w[i] = DW'(newest - i);
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one sample on the main DUT, confirm it is taken, clock it in.
  task automatic feed(input int v, input string tag);
    sampleIn    = DW'(v);
    sampleValid = 1'b1;
    #1;
    chk({tag, "_ready"}, 128'(sampleReady), 128'd1);
    cyc();
    sampleValid = 1'b0;
  endtask

  initial begin
    logic [NR-1:0][DW-1:0] zexp;
    rstN = 1'b0; flush = 1'b0; windowReady = 1'b1;
    sampleIn = '0; sampleValid = 1'b0;
    z_sampleIn = '0; z_sampleValid = 1'b0;

    #2;
    chk("rst_wvalid", 128'(windowValid), 128'd0);
    chk("rst_fill",   128'(fillCount),   128'd0);
    chk("rst_data",   pDataOut,          128'd0);
    #10 rstN = 1'b1;
    #1;
    chk("rst_ready",  128'(sampleReady), 128'd1);

    // Prime: zero-primed DUT gets -5 in the same cycle as sample 1.
    cyc();
    z_sampleIn = -16'sd5; z_sampleValid = 1'b1;
    for (int k = 1; k <= NR; k++) begin
      feed(k, "prime");
      z_sampleValid = 1'b0;
      if (k == 1) begin
        zexp = '0;
        zexp[0] = 16'hFFFB;
        chk("zp_wvalid", 128'(z_windowValid), 128'd1);
        chk("zp_data",   z_pDataOut,          zexp);
        chk("zp_fill",   128'(z_fillCount),   128'd1);
      end
      if (k == 2) chk("zp_consumed", 128'(z_windowValid), 128'd0);
      chk($sformatf("prime_wvalid_%0d", k), 128'(windowValid), (k == NR) ? 128'd1 : 128'd0);
      chk($sformatf("prime_fill_%0d", k), 128'(fillCount), 128'(k));
    end
    chk("prime_data", pDataOut, mkwin(8));

    // Steady stream
    for (int k = 9; k <= 10; k++) begin
      feed(k, "stream");
      chk($sformatf("stream_wvalid_%0d", k), 128'(windowValid), 128'd1);
      chk($sformatf("stream_data_%0d", k), pDataOut, mkwin(k));
    end

    // Backpressure with sample 11 pending
    windowReady = 1'b0; sampleIn = 16'sd11; sampleValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready_%0d", c), 128'(sampleReady), 128'd0);
      cyc();
      chk($sformatf("bp_data_%0d", c), pDataOut, mkwin(10));
      chk($sformatf("bp_wvalid_%0d", c), 128'(windowValid), 128'd1);
    end
    windowReady = 1'b1;
    feed(11, "bp_release");
    chk("bp_data_11", pDataOut, mkwin(11));
    chk("bp_fill", 128'(fillCount), 128'd8);

    // Flush with sample 12 offered in the same cycle
    flush = 1'b1; sampleIn = 16'sd12; sampleValid = 1'b1;
    #1;
    chk("flush_ready", 128'(sampleReady), 128'd0);
    cyc();
    flush = 1'b0; sampleValid = 1'b0;
    chk("flush_data",   pDataOut,          128'd0);
    chk("flush_wvalid", 128'(windowValid), 128'd0);
    chk("flush_fill",   128'(fillCount),   128'd0);

    // Re-prime after flush; hold the final window unconsumed
    for (int k = 20; k <= 27; k++) begin
      if (k == 27) windowReady = 1'b0;
      feed(k, "reprime");
      chk($sformatf("reprime_wvalid_%0d", k), 128'(windowValid), (k == 27) ? 128'd1 : 128'd0);
    end
    chk("reprime_data", pDataOut, mkwin(27));
    chk("reprime_fill", 128'(fillCount), 128'd8);

    // Async reset between clock edges
    #2 rstN = 1'b0;
    #1;
    chk("arst_wvalid", 128'(windowValid), 128'd0);
    chk("arst_fill",   128'(fillCount),   128'd0);
    chk("arst_data",   pDataOut,          128'd0);
    #2 rstN = 1'b1;
    windowReady = 1'b1;
    #1;
    chk("arst_ready", 128'(sampleReady), 128'd1);
    cyc();
    for (int k = 30; k <= 37; k++) begin
      feed(k, "arst_prime");
      chk($sformatf("arst_wvalid_%0d", k), 128'(windowValid), (k == 37) ? 128'd1 : 128'd0);
    end
    chk("arst_prime_data", pDataOut, mkwin(37));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/fir_tap_window.md
Name: fir_tap_window

Overview:
- Upstream feeder for the combinational multiply-accumulate stage.
- Accepts one signed sensor sample per valid/ready handshake and shifts it into a NUM_REGS-deep tap delay line.
- Presents the whole tap window in parallel, registered, to the MAC.
- A window/valid handshake throttles the sensor side when the downstream consumer stalls.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH, signed sample width in bits.
- NUM_REGS, default `NUM_REGS, number of taps; must be >= 2.
- ZERO_PRIME, default 0. 0 = no window issued until NUM_REGS samples are held. 1 = taps start at zero and a window is issued from the first sample on.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- sampleIn  input  signed [DATA_WIDTH-1:0]  raw sensor sample.
- sampleValid  input  1  sampleIn is valid.
- sampleReady  output  1  block accepts sampleIn this cycle.
- flush  input  1  synchronous clear of the tap line.
- pDataOut  output  signed [DATA_WIDTH-1:0] [0:NUM_REGS-1]  tap window; index 0 is the newest sample.
- windowValid  output  1  pDataOut holds a window not yet consumed.
- windowReady  input  1  downstream takes the window this cycle.
- fillCount  output  [$clog2(NUM_REGS+1)-1:0]  samples held, saturating at NUM_REGS.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstN.
- Reset values: all taps 0, windowValid 0, fillCount 0, state EMPTY.
  - sampleReady is 1 as soon as rstN deasserts.
  - Reset asserted mid-stream clears everything immediately, whatever the handshake state.
- Accept: accept = sampleValid & sampleReady & ~flush.
- Ready: sampleReady = ~flush & (~windowValid | windowReady). This is a single output slot with combinational pass-through of downstream ready.
- On accept, at the next edge:
  - tap[i] <= tap[i-1] for i = 1..NUM_REGS-1, and tap[0] <= sampleIn;
  - fillCount <= min(fillCount+1, NUM_REGS).
- Latency: one cycle from accept to the updated pDataOut and windowValid.
- windowValid set at an edge with accept when:
  - ZERO_PRIME = 0 and the post-update fillCount is NUM_REGS;
  - ZERO_PRIME = 1, always.
- windowValid clear at an edge where windowValid & windowReady and there is no accept.
- Same-cycle consume and accept: windowValid stays 1 and the new window appears. Full throughput is 1 sample per clock.
- Stall: while windowValid & ~windowReady:
  - taps are frozen and sampleReady = 0;
  - pDataOut must not change until it is consumed.
- State machine, held as state plus fillCount:
  - EMPTY (fillCount = 0) -> FILLING on the first accept.
  - FILLING -> FULL when an accept brings fillCount to NUM_REGS.
  - FULL stays FULL; once there, every accept issues a window.
  - Any state -> EMPTY on flush.
  - With ZERO_PRIME = 1, FILLING still tracks fillCount but does not gate windowValid.
- Flush: synchronous and highest priority after reset.
  - Taps go to 0, fillCount to 0, windowValid to 0, state to EMPTY.
  - A sample presented in the flush cycle is not accepted, because sampleReady is 0.
  - An unconsumed window is discarded.
- Arithmetic: fillCount saturates and never wraps. There is no arithmetic on sample data; values are passed bit-exact, sign preserved.
- NUM_REGS = 1 is illegal; an elaboration-time assertion rejects it.

Decomposition:
- Shared package fir_pkg:
  - tap_state_t enum {EMPTY, FILLING, FULL};
  - the DATA_WIDTH / NUM_REGS / Q_FORMAT defaults, so the MAC and this block elaborate from one source;
  - a sample_t typedef, signed [DATA_WIDTH-1:0].
- One natural sub-module, fir_tap_shift: a parameterised enable-plus-clear shift register with parallel output.
- Handshake, fill counter and state machine stay in the fir_tap_window top.

Test Plan:
- Prime (NUM_REGS = 8, ZERO_PRIME = 0, windowReady = 1): feed 1..8 on consecutive cycles.
  - Required: windowValid = 0 through the 7th accept.
  - One cycle after the 8th accept: windowValid = 1, pDataOut = {8,7,6,5,4,3,2,1}, fillCount = 8.
- Steady stream: continue with 9, 10.
  - Required: consecutive windows {9..2} and {10..3}, with windowValid held at 1 and sampleReady at 1 each cycle.
- Backpressure: hold windowReady = 0 for 3 cycles with sampleValid = 1 and sample 11 pending.
  - Required: sampleReady = 0 and pDataOut frozen at {10..3} for those 3 cycles.
  - On the cycle windowReady = 1: 11 is accepted, and the next window is {11..4}.
- Flush: assert flush in the same cycle as sampleValid = 1 with sample 12.
  - Required: sampleReady = 0, 12 is not captured.
  - Next cycle: taps all 0, windowValid = 0, fillCount = 0.
  - Priming restarts and needs 8 new samples.
- ZERO_PRIME = 1: after reset feed -5.
  - Required: next cycle windowValid = 1, pDataOut = {-5,0,0,0,0,0,0,0}, fillCount = 1.
- Async reset: drop rstN between clock edges mid-stream, with windowValid = 1 and fillCount = 8.
  - Required: all outputs reach reset values without waiting for a clk edge.
  - sampleReady = 1 after release.
  - The first window needs 8 fresh samples.
